// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared state encodings, product width and parameter defaults for prod_accum.
package prod_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, HOLD = 2'b10} state_t;
  localparam int PROD_W = 4;
  localparam int N_DEF = 4;
  localparam int ACC_W_DEF = 8;
endpackage

// File: rtl/prod_accum_fsm.sv
// prod_accum_fsm: batch control FSM and product counter for prod_accum.
module prod_accum_fsm
  import prod_accum_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic first,
  output logic handoff
);
  state_t state, next;
  logic [7:0] cnt, cnt_inc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= (clear || handoff) ? '0 : accept ? cnt_inc : cnt;
    end
  end
  always_comb begin
    in_ready = state != HOLD;
    out_valid = state == HOLD;
    accept = in_valid && in_ready && !clear;
    first = accept && state == IDLE;
    handoff = out_valid && out_ready && !clear;
    cnt_inc = first ? 8'd1 : cnt + 8'd1;
    next = state;
    if (clear || handoff) next = IDLE;
    else if (accept) next = cnt_inc == 8'(N) ? HOLD : ACC;
  end
endmodule

// File: rtl/prod_accum.sv
// prod_accum: accumulates N products per batch and presents the sum with a valid/ready hand-off.
// Define PROD_ACCUM_SAT_EN to clamp the sum at its maximum instead of wrapping.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);
  logic accept, first, handoff, ovf;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W:0] sum;
  prod_accum_fsm #(.N(N)) u_fsm (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .accept(accept), .first(first), .handoff(handoff)
  );
  // The first product of a batch loads rather than adds, so a stale acc never leaks in.
  assign sum = (first ? '0 : {1'b0, acc}) + (ACC_W + 1)'(prod);
`ifdef PROD_ACCUM_SAT_EN
  assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear || handoff) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      ovf <= ovf | sum[ACC_W];
    end
  end
  assign acc_out = acc;
  assign overflow = ovf;
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed and random checks of three prod_accum configurations against a batch-sum model.
module tb_prod_accum;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [3:0] prod = 0;
  logic [7:0] a8, a1;
  logic [4:0] a5;
  logic ir[3], vo[3], ov[3];
  logic [15:0] oacc[3];
  int total = 0, bad = 0;
  int mcnt[3], mtot[3];
  bit mhold[3];
  int nn[3] = '{4, 4, 1};
  int ww[3] = '{8, 5, 8};
  bit sat;

  always #5 clk = ~clk;

  prod_accum #(.N(4), .ACC_W(8)) dut_a (.clk(clk), .rst(rst), .clear(clear), .prod(prod),
    .in_valid(in_valid), .in_ready(ir[0]), .acc_out(a8), .out_valid(vo[0]), .out_ready(out_ready), .overflow(ov[0]));
  prod_accum #(.N(4), .ACC_W(5)) dut_b (.clk(clk), .rst(rst), .clear(clear), .prod(prod),
    .in_valid(in_valid), .in_ready(ir[1]), .acc_out(a5), .out_valid(vo[1]), .out_ready(out_ready), .overflow(ov[1]));
  prod_accum #(.N(1), .ACC_W(8)) dut_c (.clk(clk), .rst(rst), .clear(clear), .prod(prod),
    .in_valid(in_valid), .in_ready(ir[2]), .acc_out(a1), .out_valid(vo[2]), .out_ready(out_ready), .overflow(ov[2]));

  assign oacc[0] = {8'b0, a8};
  assign oacc[1] = {11'b0, a5};
  assign oacc[2] = {8'b0, a1};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_acc(input int i);
    int mx = (1 << ww[i]) - 1;
    return sat ? (mtot[i] > mx ? mx : mtot[i]) : mtot[i] % (mx + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mtot[i] = 0;
      mhold[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.u%0d.in_ready", tag, i), 16'(ir[i]), 16'(!mhold[i]));
      chk($sformatf("%s.u%0d.out_valid", tag, i), 16'(vo[i]), 16'(mhold[i]));
      chk($sformatf("%s.u%0d.acc_out", tag, i), oacc[i], 16'(exp_acc(i)));
      chk($sformatf("%s.u%0d.overflow", tag, i), 16'(ov[i]), 16'(mtot[i] > (1 << ww[i]) - 1));
    end
  endtask

  task automatic step(input string tag, input bit v, input int p, input bit ordy, input bit clr);
    in_valid = v;
    prod = 4'(p);
    out_ready = ordy;
    clear = clr;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mcnt[i] = 0; mtot[i] = 0; mhold[i] = 0;
      end else if (mhold[i]) begin
        if (ordy) begin
          mcnt[i] = 0; mtot[i] = 0; mhold[i] = 0;
        end
      end else if (v) begin
        mtot[i] += p;
        mcnt[i]++;
        if (mcnt[i] == nn[i]) mhold[i] = 1;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
`ifdef PROD_ACCUM_SAT_EN
    sat = 1;
`else
    sat = 0;
`endif
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 0;
    // Basic batch 1+2+4+9 with a ready consumer.
    step("basic", 1, 1, 1, 0);
    step("basic", 1, 2, 1, 0);
    step("basic", 1, 4, 1, 0);
    step("basic", 1, 9, 1, 0);
    chk("basic_sum", 16'(a8), 16'd16);
    chk("basic_valid", 16'(vo[0]), 16'd1);
    step("basic_ho", 0, 0, 1, 0);
    chk("basic_drop", 16'(vo[0]), 16'd0);
    // Gapped input and a stalled consumer.
    for (int k = 0; k < 4; k++) begin
      repeat (3) step("gap", 0, 0, 0, 0);
      step("gap", 1, k + 5, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      step("stall", 1, 7, 0, 0);
      chk("stall_sum", 16'(a8), 16'd26);
      chk("stall_ready", 16'(ir[0]), 16'd0);
    end
    step("stall_ho", 0, 0, 1, 0);
    chk("stall_ho_valid", 16'(vo[0]), 16'd0);
    step("clr0", 0, 0, 0, 1);
    // Overflow batch on the 5-bit instance.
    repeat (4) step("ovf", 1, 9, 0, 0);
    chk("ovf_flag", 16'(ov[1]), 16'd1);
    chk("ovf_sum", 16'(a5), sat ? 16'd31 : 16'd4);
    step("ovf_ho", 0, 0, 1, 0);
    chk("ovf_cleared", 16'(ov[1]), 16'd0);
    // Clear in the same cycle as a valid product.
    step("clr", 1, 3, 0, 0);
    step("clr", 1, 3, 0, 0);
    step("clr_pulse", 1, 3, 0, 1);
    repeat (4) step("clr_batch", 1, 3, 0, 0);
    chk("clr_sum", 16'(a8), 16'd12);
    step("clr_ho", 0, 0, 1, 0);
    // Asynchronous reset while holding a result.
    repeat (4) step("arst", 1, 5, 0, 0);
    chk("arst_hold", 16'(vo[0]), 16'd1);
    #2 rst = 1;
    model_reset();
    #1;
    check_all("arst_mid");
    #2 rst = 0;
    repeat (4) step("arst_batch", 1, 1, 0, 0);
    chk("arst_sum", 16'(a8), 16'd4);
    step("arst_clr", 0, 0, 0, 1);
    // Single-product batches.
    step("n1", 1, 6, 0, 0);
    chk("n1_valid", 16'(vo[2]), 16'd1);
    chk("n1_sum", 16'(a1), 16'd6);
    step("n1_ho", 0, 0, 1, 0);
    // Random traffic.
    for (int k = 0; k < 400; k++)
      step("rand", 1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning products accumulated per batch (legal 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 8, meaning accumulator width in bits (legal 4..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clear  input  1  synchronous batch abort.
REQ-006 prod  input  4  unsigned product from the upstream 2x2 array multiplier, as {c3,c2,c1,c0}.
REQ-007 in_valid  input  1  prod is valid this cycle.
REQ-008 in_ready  output  1  block accepts prod this cycle.
REQ-009 acc_out  output  ACC_W  batch sum.
REQ-010 out_valid  output  1  acc_out holds a completed batch.
REQ-011 out_ready  input  1  consumer takes acc_out this cycle.
REQ-012 overflow  output  1  sticky; batch sum exceeded 2^ACC_W-1.

Function
REQ-013 The block SHALL implement states IDLE, ACC, HOLD.
REQ-014 An accept SHALL occur on a rising edge where in_valid=1, in_ready=1 and clear=0.
REQ-015 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-016 IDLE accept SHALL load acc=zero-extended prod, cnt=1, go to ACC, or to HOLD when N=1.
REQ-017 ACC accept SHALL set acc=acc+prod, cnt=cnt+1, and go to HOLD when the new cnt equals N.
REQ-018 Cycles with in_valid=0 SHALL leave acc, cnt and state unchanged; gaps are unlimited.
REQ-019 out_valid SHALL rise the cycle after the Nth accept; acc_out and overflow SHALL stay stable while out_valid=1.
REQ-020 In HOLD, out_ready=1 SHALL hand off: next state IDLE, acc=0, cnt=0, overflow=0; out_ready is ignored outside HOLD.
REQ-021 Back-to-back: the first product of the next batch SHALL be accepted no earlier than the cycle after hand-off.
REQ-022 prod SHALL be treated as any 4-bit unsigned value; the block SHALL NOT check prod<=9.
REQ-023 overflow SHALL set on any accept whose true sum exceeds 2^ACC_W-1 and hold until hand-off, clear or reset.
REQ-024 clear=1 SHALL override every other event in any state: next state IDLE, acc=0, cnt=0, overflow=0; no accept, no hand-off.
REQ-025 acc_out SHALL equal the internal acc in every state.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, acc=0, cnt=0, out_valid=0, overflow=0, acc_out=0, in_ready=1.
REQ-027 Reset asserted mid-batch or in HOLD SHALL discard the batch; no partial result is presented.
REQ-028 The first accept after rst falls SHALL be treated as the first product of a new batch.

Configuration
REQ-029 Macro PROD_ACCUM_SAT_EN SHALL select overflow handling.
REQ-030 With PROD_ACCUM_SAT_EN defined, an overflowing accept SHALL clamp acc to 2^ACC_W-1, and later accepts SHALL keep it there.
REQ-031 Without it, acc SHALL wrap modulo 2^ACC_W; overflow SHALL behave identically in both builds.

Structure
REQ-032 The shared package SHALL hold the state encodings (IDLE=2'b00, ACC=2'b01, HOLD=2'b10), PROD_W=4, and the defaults for N and ACC_W.
REQ-033 The control FSM and cnt SHALL be a sub-module prod_accum_fsm; the datapath (adder, clamp, acc register) SHALL stay in prod_accum.

Verification
REQ-034 N=4, ACC_W=8, prod 1,2,4,9 with no gaps, out_ready=1 -> acc_out=16, out_valid high for exactly 1 cycle, 1 cycle after the 4th accept, overflow=0.
REQ-035 N=4, in_valid gaps of 3 cycles, out_ready held 0 for 5 cycles -> in_ready=0 and acc_out stable throughout HOLD; hand-off on the first out_ready=1.
REQ-036 N=4, ACC_W=5, prod 9,9,9,9 -> overflow=1; acc_out=31 with PROD_ACCUM_SAT_EN, acc_out=4 without.
REQ-037 clear pulsed after 2 accepts with in_valid=1 in the same cycle -> that prod is not accepted; the next 4 accepts of 3 give acc_out=12.
REQ-038 rst pulsed asynchronously (mid-cycle) in HOLD -> out_valid, acc_out and overflow drop to 0 before the next edge; a following batch of 4x1 gives acc_out=4.
REQ-039 N=1, prod 6 -> out_valid the cycle after the accept, acc_out=6.
